// File: rtl/dynamic_budget_tracker.sv
// Per-channel outstanding-cost accumulator with a countdown budget that is
// reloaded on activity, decremented by a shared prescaler, and a sticky timeout.
module dynamic_budget_tracker #(
    parameter int NumChannels   = 2,
    parameter int MaxTxns       = 8,
    parameter int LenWidth      = 8,
    parameter int PrescalerDiv  = 2,
    parameter int FixedOverhead = 5,
    parameter int CntWidth      = 16,
    localparam int SlotW = (MaxTxns > 1) ? $clog2(MaxTxns) : 1,
    localparam int OutW  = $clog2(MaxTxns + 1)
) (
    input  logic                                  clk_i,
    input  logic                                  rst_i,
    input  logic [NumChannels-1:0]                add_valid_i,
    input  logic [NumChannels-1:0][SlotW-1:0]     add_slot_i,
    input  logic [NumChannels-1:0][LenWidth-1:0]  add_len_i,
    input  logic [NumChannels-1:0]                ret_valid_i,
    input  logic [NumChannels-1:0][SlotW-1:0]     ret_slot_i,
    input  logic [NumChannels-1:0]                beat_i,
    input  logic [NumChannels-1:0]                clear_i,
    output logic [NumChannels-1:0][CntWidth-1:0]  accum_o,
    output logic [NumChannels-1:0][OutW-1:0]      outstanding_o,
    output logic [NumChannels-1:0][CntWidth-1:0]  budget_o,
    output logic [NumChannels-1:0]                timeout_o,
    output logic [NumChannels-1:0]                err_o
);

    localparam int Slots = 1 << SlotW;
    localparam int ShW   = $clog2(PrescalerDiv);
    localparam int PreW  = (PrescalerDiv > 1) ? $clog2(PrescalerDiv) : 1;
    localparam int LenW1 = LenWidth + 1;
    localparam int CalcW = (LenW1 > CntWidth) ? LenW1 : CntWidth;
    // Slot indices at or above MaxTxns are never allocatable.
    localparam logic [Slots-1:0] SlotMask = {Slots{1'b1}} >> (Slots - MaxTxns);

    logic [PreW-1:0] presc_q;
    logic [PreW-1:0] presc_d;
    logic            tick;

    assign tick    = (presc_q == PreW'(PrescalerDiv - 1));
    assign presc_d = tick ? '0 : presc_q + PreW'(1);

    always_ff @(posedge clk_i) begin
        if (rst_i) presc_q <= '0;
        else       presc_q <= presc_d;
    end

    for (genvar c = 0; c < NumChannels; c++) begin : g_ch
        logic [Slots-1:0]                occ_q, occ_d;
        logic [Slots-1:0][CntWidth-1:0]  cost_q, cost_d;
        logic [CntWidth-1:0]             accum_q, accum_d;
        logic [CntWidth-1:0]             budget_q, budget_d;
        logic [OutW-1:0]                 out_q, out_d;
        logic                            timeout_q, timeout_d;
        logic                            err_q, err_d;
        logic [CntWidth-1:0]             new_cost;
        logic [CalcW-1:0]                len_ext;
        logic [CntWidth:0]               sum;
        logic                            reload;

        // len+1 is formed one bit wider so a full-length burst does not wrap.
        assign len_ext  = (CalcW'(add_len_i[c]) + CalcW'(1)) >> ShW;
        assign new_cost = len_ext[CntWidth-1:0] + CntWidth'(FixedOverhead);
        assign reload   = add_valid_i[c] | ret_valid_i[c] | beat_i[c];

        always_comb begin
            occ_d     = occ_q;
            cost_d    = cost_q;
            accum_d   = accum_q;
            out_d     = out_q;
            err_d     = 1'b0;
            sum       = '0;
            budget_d  = budget_q;
            timeout_d = timeout_q;

            if (ret_valid_i[c]) begin
                if (occ_q[ret_slot_i[c]]) begin
                    occ_d[ret_slot_i[c]] = 1'b0;
                    accum_d = (accum_d > cost_q[ret_slot_i[c]])
                            ? accum_d - cost_q[ret_slot_i[c]] : '0;
                    out_d = out_d - OutW'(1);
                end else begin
                    err_d = 1'b1;
                end
            end

            // Evaluated against the post-retire map so retire+add to one slot is legal.
            if (add_valid_i[c]) begin
                if (SlotMask[add_slot_i[c]] && !occ_d[add_slot_i[c]]) begin
                    occ_d[add_slot_i[c]]  = 1'b1;
                    cost_d[add_slot_i[c]] = new_cost;
                    sum = {1'b0, accum_d} + {1'b0, new_cost};
                    accum_d = sum[CntWidth] ? '1 : sum[CntWidth-1:0];
                    out_d = out_d + OutW'(1);
                end else begin
                    err_d = 1'b1;
                end
            end

            if (reload) begin
                budget_d = accum_d;
            end else if (tick && out_q != '0 && budget_q != '0) begin
                budget_d = budget_q - CntWidth'(1);
            end

            if (clear_i[c]) begin
                timeout_d = 1'b0;
            end else if (budget_q == '0 && out_q != '0 && !reload) begin
                timeout_d = 1'b1;
            end
        end

        always_ff @(posedge clk_i) begin
            if (rst_i) begin
                occ_q     <= '0;
                cost_q    <= '0;
                accum_q   <= '0;
                budget_q  <= '0;
                out_q     <= '0;
                timeout_q <= 1'b0;
                err_q     <= 1'b0;
            end else begin
                occ_q     <= occ_d;
                cost_q    <= cost_d;
                accum_q   <= accum_d;
                budget_q  <= budget_d;
                out_q     <= out_d;
                timeout_q <= timeout_d;
                err_q     <= err_d;
            end
        end

        assign accum_o[c]       = accum_q;
        assign outstanding_o[c] = out_q;
        assign budget_o[c]      = budget_q;
        assign timeout_o[c]     = timeout_q;
        assign err_o[c]         = err_q;
    end

endmodule

// File: tb/tb_dynamic_budget_tracker.sv
// Randomized and directed bench for dynamic_budget_tracker against a
// slot-table reference model.
module tb_dynamic_budget_tracker;

    localparam int NC  = 2;
    localparam int MT  = 8;
    localparam int LW  = 8;
    localparam int DIV = 2;
    localparam int FO  = 5;
    localparam int CW  = 8;
    localparam int SW  = 3;
    localparam int OW  = 4;
    localparam int CMAX = (1 << CW) - 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                    rst;
    logic [NC-1:0]           add_valid, ret_valid, beat, clear;
    logic [NC-1:0][SW-1:0]   add_slot, ret_slot;
    logic [NC-1:0][LW-1:0]   add_len;
    logic [NC-1:0][CW-1:0]   accum, budget;
    logic [NC-1:0][OW-1:0]   outstanding;
    logic [NC-1:0]           timeout, err;

    int checks = 0;
    int errors = 0;

    bit m_occ  [NC][MT];
    int m_cost [NC][MT];
    int m_acc  [NC];
    int m_out  [NC];
    int m_bud  [NC];
    bit m_to   [NC];
    bit m_err  [NC];
    int m_phase;

    dynamic_budget_tracker #(
        .NumChannels(NC), .MaxTxns(MT), .LenWidth(LW),
        .PrescalerDiv(DIV), .FixedOverhead(FO), .CntWidth(CW)
    ) dut (
        .clk_i(clk), .rst_i(rst),
        .add_valid_i(add_valid), .add_slot_i(add_slot), .add_len_i(add_len),
        .ret_valid_i(ret_valid), .ret_slot_i(ret_slot),
        .beat_i(beat), .clear_i(clear),
        .accum_o(accum), .outstanding_o(outstanding), .budget_o(budget),
        .timeout_o(timeout), .err_o(err)
    );

    task automatic idle();
        add_valid = '0; ret_valid = '0; beat = '0; clear = '0;
        add_slot = '0; ret_slot = '0; add_len = '0;
    endtask

    // Advance one clock edge, update the model from the inputs sampled there.
    task automatic cycle();
        bit tick;
        @(posedge clk);
        if (rst) begin
            m_phase = 0;
            for (int c = 0; c < NC; c++) begin
                for (int s = 0; s < MT; s++) begin
                    m_occ[c][s] = 0; m_cost[c][s] = 0;
                end
                m_acc[c] = 0; m_out[c] = 0; m_bud[c] = 0;
                m_to[c] = 0; m_err[c] = 0;
            end
        end else begin
            tick = ((m_phase % DIV) == DIV - 1);
            m_phase++;
            for (int c = 0; c < NC; c++) begin
                int acc, out, s, cst;
                bit e, rl;
                acc = m_acc[c]; out = m_out[c]; e = 0;
                rl = add_valid[c] | ret_valid[c] | beat[c];
                if (ret_valid[c]) begin
                    s = int'(ret_slot[c]);
                    if (m_occ[c][s]) begin
                        m_occ[c][s] = 0;
                        acc = acc - m_cost[c][s];
                        if (acc < 0) acc = 0;
                        out--;
                    end else e = 1;
                end
                if (add_valid[c]) begin
                    s = int'(add_slot[c]);
                    if (!m_occ[c][s]) begin
                        cst = ((int'(add_len[c]) + 1) / DIV + FO) % (CMAX + 1);
                        m_occ[c][s] = 1;
                        m_cost[c][s] = cst;
                        acc = acc + cst;
                        if (acc > CMAX) acc = CMAX;
                        out++;
                    end else e = 1;
                end
                if (clear[c]) m_to[c] = 0;
                else if (m_bud[c] == 0 && m_out[c] > 0 && !rl) m_to[c] = 1;
                if (rl) m_bud[c] = acc;
                else if (tick && m_out[c] > 0 && m_bud[c] > 0) m_bud[c]--;
                m_acc[c] = acc; m_out[c] = out; m_err[c] = e;
            end
        end
        #1;
    endtask

    task automatic test_reset();
        idle();
        rst = 1'b1;
        add_valid = '1; add_len = '1; beat = '1;
        cycle();
        cycle();
        rst = 1'b0;
        idle();
        for (int c = 0; c < NC; c++) begin
            checks++;
            if (accum[c] !== '0 || outstanding[c] !== '0 || budget[c] !== '0
                || timeout[c] !== 1'b0 || err[c] !== 1'b0) begin
                errors++;
                $display("FAIL reset ch%0d: acc=%0d out=%0d bud=%0d to=%b err=%b want all 0",
                         c, accum[c], outstanding[c], budget[c], timeout[c], err[c]);
            end
        end
    endtask

    task automatic test_single_add();
        int zero_at, to_at;
        add_valid[0] = 1'b1; add_slot[0] = 3'd3; add_len[0] = 8'd7;
        cycle();
        idle();
        checks++;
        if (accum[0] !== 8'd9 || outstanding[0] !== 4'd1 || budget[0] !== 8'd9) begin
            errors++;
            $display("FAIL single_add: acc=%0d out=%0d bud=%0d want 9 1 9",
                     accum[0], outstanding[0], budget[0]);
        end
        zero_at = -1; to_at = -1;
        for (int i = 1; i <= 60 && to_at < 0; i++) begin
            cycle();
            checks++;
            if (budget[0] !== CW'(m_bud[0]) || timeout[0] !== m_to[0]) begin
                errors++;
                $display("FAIL countdown c%0d: bud=%0d to=%b want %0d %b",
                         i, budget[0], timeout[0], m_bud[0], m_to[0]);
            end
            if (zero_at < 0 && budget[0] == '0) zero_at = i;
            if (timeout[0] === 1'b1) to_at = i;
        end
        checks++;
        if (to_at < 0 || zero_at < 17 || zero_at > 19 || to_at != zero_at + 1) begin
            errors++;
            $display("FAIL countdown_timing: zero_at=%0d to_at=%0d want 17..19 and +1",
                     zero_at, to_at);
        end
        clear[0] = 1'b1;
        cycle();
        clear[0] = 1'b0;
        checks++;
        if (timeout[0] !== 1'b0) begin
            errors++;
            $display("FAIL clear_drop: to=%b want 0", timeout[0]);
        end
        cycle();
        checks++;
        if (timeout[0] !== 1'b1) begin
            errors++;
            $display("FAIL clear_reset: to=%b want 1", timeout[0]);
        end
        ret_valid[0] = 1'b1; ret_slot[0] = 3'd3;
        cycle();
        idle();
        checks++;
        if (accum[0] !== '0 || outstanding[0] !== '0) begin
            errors++;
            $display("FAIL single_retire: acc=%0d out=%0d want 0 0", accum[0], outstanding[0]);
        end
    endtask

    task automatic test_replace();
        add_valid[0] = 1'b1; add_slot[0] = 3'd0; add_len[0] = 8'd3;
        cycle();
        checks++;
        if (accum[0] !== 8'd7 || outstanding[0] !== 4'd1) begin
            errors++;
            $display("FAIL replace_first: acc=%0d out=%0d want 7 1", accum[0], outstanding[0]);
        end
        ret_valid[0] = 1'b1; ret_slot[0] = 3'd0; add_len[0] = 8'd15;
        cycle();
        idle();
        checks++;
        if (accum[0] !== 8'd13 || outstanding[0] !== 4'd1 || err[0] !== 1'b0) begin
            errors++;
            $display("FAIL replace_same: acc=%0d out=%0d err=%b want 13 1 0",
                     accum[0], outstanding[0], err[0]);
        end
        ret_valid[0] = 1'b1; ret_slot[0] = 3'd0;
        cycle();
        idle();
        checks++;
        if (accum[0] !== '0 || outstanding[0] !== '0) begin
            errors++;
            $display("FAIL replace_retire: acc=%0d out=%0d want 0 0", accum[0], outstanding[0]);
        end
    endtask

    task automatic test_errors();
        add_valid[0] = 1'b1; add_slot[0] = 3'd1; add_len[0] = 8'd1;
        cycle();
        idle();
        ret_valid[0] = 1'b1; ret_slot[0] = 3'd5;
        cycle();
        idle();
        checks++;
        if (err[0] !== 1'b1 || accum[0] !== 8'd6 || outstanding[0] !== 4'd1) begin
            errors++;
            $display("FAIL err_retire_free: err=%b acc=%0d out=%0d want 1 6 1",
                     err[0], accum[0], outstanding[0]);
        end
        cycle();
        checks++;
        if (err[0] !== 1'b0) begin
            errors++;
            $display("FAIL err_pulse1: err=%b want 0", err[0]);
        end
        add_valid[0] = 1'b1; add_slot[0] = 3'd1; add_len[0] = 8'd100;
        cycle();
        idle();
        checks++;
        if (err[0] !== 1'b1 || accum[0] !== 8'd6 || outstanding[0] !== 4'd1) begin
            errors++;
            $display("FAIL err_add_occupied: err=%b acc=%0d out=%0d want 1 6 1",
                     err[0], accum[0], outstanding[0]);
        end
        cycle();
        checks++;
        if (err[0] !== 1'b0) begin
            errors++;
            $display("FAIL err_pulse2: err=%b want 0", err[0]);
        end
        ret_valid[0] = 1'b1; ret_slot[0] = 3'd1;
        cycle();
        idle();
    endtask

    task automatic test_saturate();
        for (int s = 0; s < MT; s++) begin
            add_valid[1] = 1'b1; add_slot[1] = SW'(s); add_len[1] = 8'd255;
            cycle();
            checks++;
            if (accum[1] !== CW'(m_acc[1]) || outstanding[1] !== OW'(s + 1)) begin
                errors++;
                $display("FAIL sat_fill s%0d: acc=%0d out=%0d want %0d %0d",
                         s, accum[1], outstanding[1], m_acc[1], s + 1);
            end
        end
        idle();
        checks++;
        if (accum[1] !== 8'd255) begin
            errors++;
            $display("FAIL sat_peak: acc=%0d want 255", accum[1]);
        end
        for (int s = 0; s < MT; s++) begin
            ret_valid[1] = 1'b1; ret_slot[1] = SW'(s);
            cycle();
        end
        idle();
        checks++;
        if (accum[1] !== '0 || outstanding[1] !== '0) begin
            errors++;
            $display("FAIL sat_drain: acc=%0d out=%0d want 0 0", accum[1], outstanding[1]);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            for (int c = 0; c < NC; c++) begin
                add_valid[c] = ($urandom_range(9, 0) < 4);
                ret_valid[c] = ($urandom_range(9, 0) < 4);
                beat[c]      = ($urandom_range(19, 0) == 0);
                clear[c]     = ($urandom_range(9, 0) == 0);
                add_slot[c]  = SW'($urandom_range(MT - 1, 0));
                ret_slot[c]  = SW'($urandom_range(MT - 1, 0));
                add_len[c]   = LW'($urandom_range(255, 0));
            end
            cycle();
            for (int c = 0; c < NC; c++) begin
                checks++;
                if (accum[c] !== CW'(m_acc[c]) || outstanding[c] !== OW'(m_out[c])
                    || budget[c] !== CW'(m_bud[c]) || timeout[c] !== m_to[c]
                    || err[c] !== m_err[c]) begin
                    errors++;
                    $display("FAIL random i%0d ch%0d: acc=%0d out=%0d bud=%0d to=%b err=%b want %0d %0d %0d %b %b",
                             i, c, accum[c], outstanding[c], budget[c], timeout[c], err[c],
                             m_acc[c], m_out[c], m_bud[c], m_to[c], m_err[c]);
                end
            end
        end
        idle();
    endtask

    task automatic test_reset_mid();
        int seen;
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        add_valid = 2'b11;
        add_slot[0] = 3'd2; add_len[0] = 8'd9;
        add_slot[1] = 3'd0; add_len[1] = 8'd1;
        cycle();
        idle();
        ret_valid[1] = 1'b1; ret_slot[1] = 3'd0;
        add_valid[1] = 1'b1; add_slot[1] = 3'd4; add_len[1] = 8'd3;
        cycle();
        idle();
        checks++;
        if (accum[1] !== 8'd7 || outstanding[1] !== 4'd1
            || accum[0] !== 8'd10 || outstanding[0] !== 4'd1) begin
            errors++;
            $display("FAIL indep: acc1=%0d out1=%0d acc0=%0d out0=%0d want 7 1 10 1",
                     accum[1], outstanding[1], accum[0], outstanding[0]);
        end
        seen = 0;
        for (int i = 0; i < 60 && !seen; i++) begin
            beat[0] = (i % 4 == 0);
            cycle();
            checks++;
            if (budget[0] !== CW'(m_bud[0]) || budget[1] !== CW'(m_bud[1])) begin
                errors++;
                $display("FAIL mid_countdown i%0d: bud0=%0d bud1=%0d want %0d %0d",
                         i, budget[0], budget[1], m_bud[0], m_bud[1]);
            end
            if (timeout[1] === 1'b1) seen = 1;
        end
        idle();
        checks++;
        if (!seen || timeout[0] !== 1'b0) begin
            errors++;
            $display("FAIL mid_timeout: to1_seen=%0d to0=%b want 1 0", seen, timeout[0]);
        end
        rst = 1'b1;
        add_valid = 2'b11; ret_valid = 2'b11; beat = 2'b11;
        add_slot[0] = 3'd6; add_len = '1;
        cycle();
        rst = 1'b0;
        idle();
        for (int c = 0; c < NC; c++) begin
            checks++;
            if (accum[c] !== '0 || outstanding[c] !== '0 || budget[c] !== '0
                || timeout[c] !== 1'b0 || err[c] !== 1'b0) begin
                errors++;
                $display("FAIL mid_reset ch%0d: acc=%0d out=%0d bud=%0d to=%b err=%b want all 0",
                         c, accum[c], outstanding[c], budget[c], timeout[c], err[c]);
            end
        end
        cycle();
        checks++;
        if (timeout !== '0 || outstanding !== '0) begin
            errors++;
            $display("FAIL post_reset: to=%b out=%h want 0 0", timeout, outstanding);
        end
    endtask

    initial begin
        rst = 1'b1;
        idle();
        m_phase = 0;
        test_reset();
        test_single_add();
        test_replace();
        test_errors();
        test_saturate();
        test_random();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
